// File: rtl/pong_pkg.sv
// Shared select codes, FSM state encoding and default byte width for the pong
// core state reader.
package pong_pkg;

  localparam int DEFAULT_DATA_W = 8;

  localparam logic [1:0] SEL_BALL_X   = 2'd0;
  localparam logic [1:0] SEL_BALL_Y   = 2'd1;
  localparam logic [1:0] SEL_PADDLE_L = 2'd2;
  localparam logic [1:0] SEL_PADDLE_R = 2'd3;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SCAN    = 3'd1,
    PRESENT = 3'd2,
    TICK_HI = 3'd3,
    TICK_LO = 3'd4
  } state_e;

endpackage

// File: rtl/pong_sync2.sv
// Two-flop synchronizer bringing the core's asynchronous state byte into the
// clk domain.
module pong_sync2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_r;
  logic [W-1:0] sync_r;

  // Two-stage resynchronisation of the incoming byte
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_r <= '0;
      sync_r <= '0;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/pong_state_reader.sv
// Scans the pong core's four state bytes through its select mux, presents one
// atomic snapshot per game step, then pulses game_clk to advance the game.
module pong_state_reader import pong_pkg::*; #(
  parameter int DATA_W        = DEFAULT_DATA_W,
  parameter int SETTLE_CYCLES = 2,
  parameter int TICK_HALF     = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [DATA_W-1:0] game_data,
  output logic [1:0]        game_sel,
  output logic              game_clk,
  output logic              snap_valid,
  input  logic              snap_ready,
  output logic [DATA_W-1:0] ball_x,
  output logic [DATA_W-1:0] ball_y,
  output logic [DATA_W-1:0] paddle_l,
  output logic [DATA_W-1:0] paddle_r,
  output logic [15:0]       frame_cnt,
  output logic              busy
);

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] CAP_AT    = CNT_W'(SETTLE_CYCLES + 2);
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_HALF - 1);

  state_e              state_r, state_next_s;
  logic [CNT_W-1:0]    cnt_r, cnt_next_s;
  logic [1:0]          sel_r, sel_next_s;
  logic                game_clk_r, game_clk_next_s;
  logic                valid_r, valid_next_s;
  logic                cap_en_s, load_snap_s, frame_inc_s;
  logic                busy_r;
  logic [DATA_W-1:0]   sync_q_s;
  logic [DATA_W-1:0]   shadow_r [4];
  logic [DATA_W-1:0]   ball_x_r, ball_y_r, paddle_l_r, paddle_r_r;
  logic [15:0]         frame_cnt_r;

  pong_sync2 #(.W(DATA_W)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (game_data),
    .q     (sync_q_s)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state and next-value decode for the scan/present/tick loop
  always_comb begin
    state_next_s    = state_r;
    cnt_next_s      = cnt_r;
    sel_next_s      = sel_r;
    game_clk_next_s = game_clk_r;
    valid_next_s    = valid_r;
    cap_en_s        = 1'b0;
    load_snap_s     = 1'b0;
    frame_inc_s     = 1'b0;
    case (state_r)
      IDLE: begin
        sel_next_s      = SEL_BALL_X;
        cnt_next_s      = '0;
        game_clk_next_s = 1'b0;
        valid_next_s    = 1'b0;
        if (enable) begin
          state_next_s = SCAN;
        end else begin
          state_next_s = IDLE;
        end
      end
      SCAN: begin
        if (cnt_r == CAP_AT) begin
          cap_en_s   = 1'b1;
          cnt_next_s = '0;
          if (sel_r == SEL_PADDLE_R) begin
            // Last byte goes straight into the snapshot so valid rises with it
            state_next_s = PRESENT;
            load_snap_s  = 1'b1;
            valid_next_s = 1'b1;
          end else begin
            sel_next_s = sel_r + 2'd1;
          end
        end else begin
          cnt_next_s = cnt_r + CNT_W'(1);
        end
      end
      PRESENT: begin
        if (valid_r && snap_ready) begin
          valid_next_s = 1'b0;
          frame_inc_s  = 1'b1;
          cnt_next_s   = '0;
          if (enable) begin
            state_next_s    = TICK_HI;
            game_clk_next_s = 1'b1;
          end else begin
            state_next_s = IDLE;
            sel_next_s   = SEL_BALL_X;
          end
        end else begin
          valid_next_s = valid_r;
        end
      end
      TICK_HI: begin
        if (cnt_r == TICK_LAST) begin
          state_next_s    = TICK_LO;
          cnt_next_s      = '0;
          game_clk_next_s = 1'b0;
        end else begin
          cnt_next_s = cnt_r + CNT_W'(1);
        end
      end
      TICK_LO: begin
        if (cnt_r == TICK_LAST) begin
          state_next_s = SCAN;
          cnt_next_s   = '0;
          sel_next_s   = SEL_BALL_X;
        end else begin
          cnt_next_s = cnt_r + CNT_W'(1);
        end
      end
      default: begin
        state_next_s    = IDLE;
        cnt_next_s      = '0;
        sel_next_s      = SEL_BALL_X;
        game_clk_next_s = 1'b0;
        valid_next_s    = 1'b0;
      end
    endcase
  end

  // Counters, control outputs, shadow and snapshot registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r       <= '0;
      sel_r       <= SEL_BALL_X;
      game_clk_r  <= 1'b0;
      valid_r     <= 1'b0;
      busy_r      <= 1'b0;
      frame_cnt_r <= 16'd0;
      ball_x_r    <= '0;
      ball_y_r    <= '0;
      paddle_l_r  <= '0;
      paddle_r_r  <= '0;
      for (int i = 0; i < 4; i++) shadow_r[i] <= '0;
    end else begin
      cnt_r      <= cnt_next_s;
      sel_r      <= sel_next_s;
      game_clk_r <= game_clk_next_s;
      valid_r    <= valid_next_s;
      busy_r     <= (state_next_s != IDLE);
      if (cap_en_s) shadow_r[sel_r] <= sync_q_s;
      if (load_snap_s) begin
        ball_x_r   <= shadow_r[SEL_BALL_X];
        ball_y_r   <= shadow_r[SEL_BALL_Y];
        paddle_l_r <= shadow_r[SEL_PADDLE_L];
        paddle_r_r <= sync_q_s;
      end
      if (frame_inc_s) frame_cnt_r <= frame_cnt_r + 16'd1;
    end
  end

  assign game_sel   = sel_r;
  assign game_clk   = game_clk_r;
  assign snap_valid = valid_r;
  assign ball_x     = ball_x_r;
  assign ball_y     = ball_y_r;
  assign paddle_l   = paddle_l_r;
  assign paddle_r   = paddle_r_r;
  assign frame_cnt  = frame_cnt_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_pong_state_reader.sv
// Directed-sequence bench for pong_state_reader with a behavioural pong core
// whose bytes are randomised between game steps.
module tb_pong_state_reader;

  logic        clk = 1'b0;
  logic        reset, enable, snap_ready;
  logic [7:0]  game_data;
  logic [1:0]  game_sel;
  logic        game_clk, snap_valid, busy;
  logic [7:0]  ball_x, ball_y, paddle_l, paddle_r;
  logic [15:0] frame_cnt;

  logic [7:0]  core_val [4];
  int          n_tests = 0;
  int          n_fail  = 0;

  pong_state_reader dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .game_data  (game_data),
    .game_sel   (game_sel),
    .game_clk   (game_clk),
    .snap_valid (snap_valid),
    .snap_ready (snap_ready),
    .ball_x     (ball_x),
    .ball_y     (ball_y),
    .paddle_l   (paddle_l),
    .paddle_r   (paddle_r),
    .frame_cnt  (frame_cnt),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Model core: combinational output mux, one game step per game_clk rise
  assign game_data = core_val[game_sel];
  always @(posedge game_clk) begin
    core_val[0] = core_val[0] + 8'd1;
    core_val[1] = 8'($urandom);
    core_val[2] = 8'($urandom);
    core_val[3] = 8'($urandom);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input int max, output int lat);
    lat = 0;
    while (snap_valid !== 1'b1 && lat < max) begin
      step(1);
      lat++;
    end
  endtask

  // Counts the game_clk high phase, then the low phase before the next scan starts
  task automatic tick_phase(output int hi, output int lo);
    hi = 0;
    lo = 0;
    while (game_clk === 1'b1 && hi < 20) begin step(1); hi++; end
    while (game_clk === 1'b0 && game_sel === 2'd3 && lo < 20) begin step(1); lo++; end
  endtask

  function automatic logic [31:0] fields();
    return {ball_x, ball_y, paddle_l, paddle_r};
  endfunction

  function automatic logic [31:0] core_word(input logic [7:0] bx);
    return {bx, core_val[1], core_val[2], core_val[3]};
  endfunction

  initial begin
    int lat, hi, lo, pulses, exp_frames;
    logic clk_seen, busy_seen;
    logic [7:0]  exp_bx;
    logic [31:0] held;

    core_val[0] = 8'h11; core_val[1] = 8'h22; core_val[2] = 8'h33; core_val[3] = 8'h44;
    reset = 1'b1; enable = 1'b0; snap_ready = 1'b0;
    step(3);
    reset = 1'b0;
    check("rst_sel", 32'(game_sel), 32'd0);
    check("rst_gclk", 32'(game_clk), 32'd0);
    check("rst_valid", 32'(snap_valid), 32'd0);
    check("rst_fields", fields(), 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    clk_seen = 1'b0; busy_seen = 1'b0;
    repeat (100) begin
      step(1);
      clk_seen |= game_clk;
      busy_seen |= busy;
    end
    check("idle_gclk", 32'(clk_seen), 32'd0);
    check("idle_busy", 32'(busy_seen), 32'd0);

    // Single frame with fixed bytes, consumer always ready
    snap_ready = 1'b1; enable = 1'b1;
    wait_valid(40, lat);
    check("first_latency", 32'(lat), 32'd21);
    check("first_fields", fields(), 32'h11223344);
    check("first_busy", 32'(busy), 32'd1);
    step(1);
    exp_frames = 1;
    check("first_frame_cnt", 32'(frame_cnt), 32'(exp_frames));
    check("first_valid_drop", 32'(snap_valid), 32'd0);
    check("first_tick_start", 32'(game_clk), 32'd1);
    tick_phase(hi, lo);
    check("tick_hi", 32'(hi), 32'd4);
    check("tick_lo", 32'(lo), 32'd4);

    // Backpressure: core bytes churn while the snapshot is held
    snap_ready = 1'b0;
    exp_bx = 8'h12;
    wait_valid(30, lat);
    check("bp_latency", 32'(lat), 32'd20);
    check("bp_fields", fields(), core_word(exp_bx));
    held = core_word(exp_bx);
    for (int i = 0; i < 10; i++) begin
      for (int k = 0; k < 4; k++) core_val[k] = 8'($urandom);
      step(1);
      check("bp_valid_hold", 32'(snap_valid), 32'd1);
      check("bp_fields_hold", fields(), held);
      check("bp_gclk_low", 32'(game_clk), 32'd0);
    end
    exp_bx = core_val[0] + 8'd1;
    snap_ready = 1'b1;
    step(1);
    exp_frames++;
    check("bp_frame_cnt", 32'(frame_cnt), 32'(exp_frames));
    check("bp_tick_start", 32'(game_clk), 32'd1);

    // Free-running frames: ball_x advances once per tick
    for (int f = 0; f < 5; f++) begin
      tick_phase(hi, lo);
      check("run_tick_hi", 32'(hi), 32'd4);
      check("run_tick_lo", 32'(lo), 32'd4);
      wait_valid(30, lat);
      check("run_latency", 32'(lat), 32'd20);
      check("run_ball_x", 32'(ball_x), 32'(exp_bx));
      check("run_fields", fields(), core_word(exp_bx));
      step(1);
      exp_frames++;
      exp_bx = exp_bx + 8'd1;
      check("run_frame_cnt", 32'(frame_cnt), 32'(exp_frames));
    end

    // Drop enable at cnt=1 of the left-paddle field
    tick_phase(hi, lo);
    check("stop_tick_hi", 32'(hi), 32'd4);
    step(11);
    check("stop_sel_at_drop", 32'(game_sel), 32'd2);
    enable = 1'b0;
    wait_valid(20, lat);
    check("stop_latency", 32'(lat), 32'd9);
    check("stop_fields", fields(), core_word(exp_bx));
    exp_frames++;
    pulses = 0; clk_seen = 1'b0;
    repeat (30) begin
      step(1);
      if (snap_valid === 1'b1) pulses++;
      clk_seen |= game_clk;
    end
    check("stop_no_repulse", 32'(pulses), 32'd0);
    check("stop_no_tick", 32'(clk_seen), 32'd0);
    check("stop_busy", 32'(busy), 32'd0);
    check("stop_sel", 32'(game_sel), 32'd0);
    check("stop_frame_cnt", 32'(frame_cnt), 32'(exp_frames));

    // Reset in the middle of the game_clk high phase
    enable = 1'b1;
    wait_valid(40, lat);
    check("restart_latency", 32'(lat), 32'd21);
    check("restart_ball_x", 32'(ball_x), 32'(exp_bx));
    step(1);
    exp_bx = exp_bx + 8'd1;
    step(2);
    check("mid_tick_high", 32'(game_clk), 32'd1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check("rst_tick_gclk", 32'(game_clk), 32'd0);
    check("rst_tick_valid", 32'(snap_valid), 32'd0);
    check("rst_tick_busy", 32'(busy), 32'd0);
    check("rst_tick_frame_cnt", 32'(frame_cnt), 32'd0);
    step(1);
    check("post_rst_busy", 32'(busy), 32'd1);
    check("post_rst_sel", 32'(game_sel), 32'd0);
    wait_valid(30, lat);
    check("post_rst_latency", 32'(lat), 32'd20);
    check("post_rst_fields", fields(), core_word(exp_bx));
    step(1);
    check("post_rst_frame_cnt", 32'(frame_cnt), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
